// File: rtl/mc_ctrl_if.sv
// Memory handshake bundle between the sequencing controller and the I/D memories.
interface mc_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;
    logic MemWrite;

    modport master (
        output imem_req,
        input  imem_ready,
        output dmem_req,
        input  dmem_ready,
        output MemWrite
    );

    modport slave (
        input  imem_req,
        output imem_ready,
        input  dmem_req,
        output dmem_ready,
        input  MemWrite
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I sequencer: steps IF/ID/EX/MEM/WB and gates the phase strobes.
module mc_ctrl (
    input  logic             clk,
    input  logic             rstn,
    input  logic [6:0]       Op,
    input  logic [2:0]       Funct3,
    input  logic             Zero,
    mc_ctrl_if.master        mem,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       NPCOp,
    output logic             RegWrite,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [31:0]      instret
);

    localparam int unsigned CNT_W = 32;

    localparam logic [1:0] NPC_SEQ  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JAL  = 2'b10;
    localparam logic [1:0] NPC_JALR = 2'b11;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        C_R, C_I, C_L, C_S, C_B, C_JAL, C_JALR, C_LUI, C_AUIPC
    } cls_e;

    state_e state_q, state_d;
    cls_e   cls_q, id_cls;
    logic   id_known;
    logic   br_taken;

    // Opcode class decode, consumed only when leaving ID.
    always_comb begin
        id_cls   = C_R;
        id_known = 1'b1;
        case (Op)
            7'b0110011: id_cls = C_R;
            7'b0010011: id_cls = C_I;
            7'b0000011: id_cls = C_L;
            7'b0100011: id_cls = C_S;
            7'b1100011: id_cls = C_B;
            7'b1101111: id_cls = C_JAL;
            7'b1100111: id_cls = C_JALR;
            7'b0110111: id_cls = C_LUI;
            7'b0010111: id_cls = C_AUIPC;
            default:    id_known = 1'b0;
        endcase
    end

    // Branch resolution from the ALU compare flag; funct3 010/011 never branch.
    always_comb begin
        br_taken = 1'b0;
        case (Funct3)
            3'b000, 3'b101, 3'b111: br_taken = Zero;
            3'b001, 3'b100, 3'b110: br_taken = ~Zero;
            default:                br_taken = 1'b0;
        endcase
    end

    // Phase register, latched class, sticky illegal flag and retire counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IF;
            cls_q   <= C_R;
            illegal <= 1'b0;
            instret <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) begin
                cls_q <= id_cls;
                if (!id_known) begin
                    illegal <= 1'b1;
                end
            end
            instret <= instret + CNT_W'(PCWrite);
        end
    end

    // Next phase and strobe decode; unused encodings fall back to IF.
    always_comb begin
        state_d      = state_q;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        RegWrite     = 1'b0;
        NPCOp        = NPC_SEQ;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.MemWrite = 1'b0;
        case (state_q)
            S_IF: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ready) begin
                    IRWrite = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                state_d = id_known ? S_EX : S_TRAP;
            end
            S_EX: begin
                case (cls_q)
                    C_B: begin
                        PCWrite = 1'b1;
                        NPCOp   = br_taken ? NPC_BR : NPC_SEQ;
                        state_d = S_IF;
                    end
                    C_L, C_S: state_d = S_MEM;
                    default:  state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.MemWrite = (cls_q == C_S);
                if (mem.dmem_ready) begin
                    if (cls_q == C_S) begin
                        PCWrite = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                case (cls_q)
                    C_JAL:   NPCOp = NPC_JAL;
                    C_JALR:  NPCOp = NPC_JALR;
                    default: NPCOp = NPC_SEQ;
                endcase
                state_d = S_IF;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

    assign state = state_q;

endmodule
